lbmem_ctrl: RTL and testbench

Sequencing controller for the 16-bit line-buffer FIFO memory (write/read pointers, full/empty flags). It fills the buffer with one line of LWIDTH pixels, then streams in lockstep so every output pixel is delayed by exactly one line. On flush it drains the remaining pixels. It sits between the upstream pixel source, the line-buffer memory and the downstream consumer; pixel data flows directly memory-to-consumer, and this block drives only control.

---
 rtl/lbmem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_lbmem_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lbmem_ctrl.sv
// Line-buffer sequencer: fills one line, then streams in lockstep so every output is
// delayed by exactly LWIDTH pixels. Optional stall statistics under LBMEM_CTRL_STATS_EN.
module lbmem_ctrl #(
  parameter int LWIDTH = 8,
  parameter int DEPTH  = 64,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_eol,
  input  logic          flush,
  output logic          mem_wen,
  output logic          mem_ren,
  output logic          mem_clr,
  input  logic          mem_full,
  input  logic          mem_empty,
  output logic          busy,
  output logic          err,
  output logic [CW-1:0] occ,
  output logic [15:0]   stall_cnt
);

  localparam int            PW       = (LWIDTH > 1) ? $clog2(LWIDTH) : 1;
  localparam logic [PW-1:0] POS_LAST = PW'(LWIDTH - 1);
  localparam logic [CW-1:0] OCC_LINE = CW'(LWIDTH);
  localparam logic [CW-1:0] OCC_CAP  = CW'(DEPTH);
  localparam logic [CW-1:0] OCC_MAX  = {CW{1'b1}};

  typedef enum logic [2:0] {INIT, IDLE, FILL, STREAM, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] occ_reg;
  logic [CW-1:0] occ_next;
  logic [PW-1:0] pos_reg;
  logic [PW-1:0] pos_next;
  logic          err_reg;
  logic          flush_pend;
  logic          err_cond;

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_clr   = 1'b0;
    case (state)
      INIT:   mem_clr = 1'b1;
      IDLE: begin
        in_ready = 1'b1;
        mem_wen  = in_valid;
      end
      FILL: begin
        in_ready = ~mem_full;
        mem_wen  = in_valid & ~mem_full;
      end
      STREAM: begin
        // Lockstep: the pixel written now pushes the one read out now.
        out_valid = in_valid;
        in_ready  = out_ready;
        mem_wen   = in_valid & out_ready;
        mem_ren   = in_valid & out_ready;
      end
      DRAIN: begin
        out_valid = (occ_reg != '0);
        mem_ren   = (occ_reg != '0) & out_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    occ_next = occ_reg;
    if (mem_wen && !mem_ren && occ_reg != OCC_MAX)
      occ_next = occ_reg + CW'(1);
    else if (mem_ren && !mem_wen && occ_reg != '0)
      occ_next = occ_reg - CW'(1);
  end

  assign pos_next = (pos_reg == POS_LAST) ? '0 : pos_reg + PW'(1);
  assign err_cond = (mem_full && occ_reg < OCC_CAP) ||
                    (mem_empty && occ_reg != '0 && mem_ren) ||
                    (mem_wen && mem_full && !mem_ren);

  assign out_eol = out_valid & (pos_reg == POS_LAST);
  assign busy    = (state != IDLE) & ~rst;
  assign err     = err_reg;
  assign occ     = occ_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT;
      occ_reg    <= '0;
      pos_reg    <= '0;
      err_reg    <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      occ_reg <= occ_next;
      err_reg <= err_reg | err_cond;
      if (mem_ren)
        pos_reg <= pos_next;
      case (state)
        INIT: begin
          flush_pend <= 1'b0;
          state      <= IDLE;
        end
        IDLE: begin
          flush_pend <= 1'b0;
          if (mem_wen)
            state <= (LWIDTH == 1) ? STREAM : FILL;
        end
        FILL: begin
          if (flush_pend) begin
            flush_pend <= 1'b0;
            state      <= DRAIN;
          end else begin
            flush_pend <= flush;
            if (occ_next == OCC_LINE)
              state <= STREAM;
          end
        end
        STREAM: begin
          if (flush_pend) begin
            flush_pend <= 1'b0;
            state      <= DRAIN;
          end else begin
            flush_pend <= flush;
          end
        end
        DRAIN: begin
          flush_pend <= 1'b0;
          if (occ_next == '0) begin
            state   <= IDLE;
            pos_reg <= '0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef LBMEM_CTRL_STATS_EN
  logic [15:0] stall_reg;

  // Counts cycles where a pixel was offered in STREAM but the consumer held off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_reg <= '0;
    else if (state == STREAM && in_valid && !out_ready && stall_reg != 16'hFFFF)
      stall_reg <= stall_reg + 16'd1;
  end

  assign stall_cnt = stall_reg;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_lbmem_ctrl.sv
// Directed bench for lbmem_ctrl with a first-word-fall-through FIFO model standing in for
// the line-buffer memory; pixel values are sequence numbers so delays are easy to verify.
module tb_lbmem_ctrl;

  localparam int LWIDTH = 8;
  localparam int DEPTH  = 64;
  localparam int CW     = $clog2(DEPTH) + 1;
`ifdef LBMEM_CTRL_STATS_EN
  localparam logic [15:0] STALL_EXP = 16'd8;
`else
  localparam logic [15:0] STALL_EXP = 16'd0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, out_eol, flush;
  logic          mem_wen, mem_ren, mem_clr, mem_full, mem_empty, busy, err;
  logic [CW-1:0] occ;
  logic [15:0]   stall_cnt;

  int vectors    = 0;
  int miscompares = 0;

  // Memory model and pixel source
  logic [15:0] mem_arr [0:DEPTH-1];
  logic [5:0]  wp, rp;
  int          cnt;
  logic [15:0] wdata, mem_rdata;
  logic        pix_clr, force_full;

  assign mem_rdata = mem_arr[rp];
  assign mem_full  = (cnt == DEPTH) || force_full;
  assign mem_empty = (cnt == 0);

  always #5 clk = ~clk;

  lbmem_ctrl #(.LWIDTH(LWIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_eol(out_eol), .flush(flush),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_clr(mem_clr), .mem_full(mem_full),
    .mem_empty(mem_empty), .busy(busy), .err(err), .occ(occ), .stall_cnt(stall_cnt)
  );

  always @(posedge clk) begin
    if (mem_clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= 0;
    end else begin
      if (mem_wen) begin
        mem_arr[wp] <= wdata;
        wp <= wp + 6'd1;
      end
      if (mem_ren)
        rp <= rp + 6'd1;
      cnt <= cnt + (mem_wen ? 1 : 0) - (mem_ren ? 1 : 0);
    end
  end

  always @(posedge clk) begin
    if (pix_clr)
      wdata <= '0;
    else if (in_valid && in_ready)
      wdata <= wdata + 16'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("vec %0d %s: observed %0h expected %0h", vectors, tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for DRAIN to start offering pixels.
  task automatic wait_out_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 4) begin
      tick();
      n++;
    end
    check(tag, {31'b0, out_valid}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    pix_clr = 1'b1; force_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_clr", {31'b0, mem_clr}, 32'd1);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_occ", {25'b0, occ}, 32'd0);

    // Reset release: one INIT cycle, then IDLE
    rst = 1'b0; pix_clr = 1'b0;
    #1;
    check("init_mem_clr", {31'b0, mem_clr}, 32'd1);
    check("init_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("idle_mem_clr", {31'b0, mem_clr}, 32'd0);
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_occ", {25'b0, occ}, 32'd0);

    // Fill one line: pixels 0..7
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < LWIDTH; i++) begin
      #1;
      check("fill_out_valid", {31'b0, out_valid}, 32'd0);
      check("fill_wen", {31'b0, mem_wen}, 32'd1);
      tick();
      check("fill_occ", {25'b0, occ}, 32'(i + 1));
    end

    // 9th pixel comes out as pixel 0
    #1;
    check("strm_out_valid", {31'b0, out_valid}, 32'd1);
    check("strm_first_rdata", {16'b0, mem_rdata}, 32'd0);
    check("strm_ren", {31'b0, mem_ren}, 32'd1);
    tick();
    check("strm_occ", {25'b0, occ}, 32'd8);

    // Stream with out_ready toggling 1010; outputs 1..8, eol on pixel 7
    begin
      int next_out = 1;
      for (int k = 0; k < 16; k++) begin
        out_ready = (k % 2 == 0);
        #1;
        check("stall_wen", {31'b0, mem_wen}, {31'b0, out_ready});
        check("stall_ren", {31'b0, mem_ren}, {31'b0, out_ready});
        check("stall_eol", {31'b0, out_eol}, {31'b0, (next_out % LWIDTH) == LWIDTH - 1});
        if (out_ready) begin
          check("stall_rdata", {16'b0, mem_rdata}, 32'(next_out));
          next_out++;
        end
        tick();
        check("stall_occ", {25'b0, occ}, 32'd8);
      end
    end
    check("stall_cnt", {16'b0, stall_cnt}, {16'b0, STALL_EXP});

    // Three more fires bring the input total to 20 (outputs 9..11)
    out_ready = 1'b1;
    for (int k = 9; k < 12; k++) begin
      #1;
      check("pre_flush_rdata", {16'b0, mem_rdata}, 32'(k));
      tick();
    end

    // Flush in STREAM: drain pixels 12..19
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_out_valid("strm_drain_start");
    for (int j = 0; j < LWIDTH; j++) begin
      check("drain_in_ready", {31'b0, in_ready}, 32'd0);
      check("drain_rdata", {16'b0, mem_rdata}, 32'(12 + j));
      check("drain_eol", {31'b0, out_eol}, {31'b0, j == 3});
      tick();
      check("drain_occ", {25'b0, occ}, 32'(7 - j));
    end
    check("drain_idle_busy", {31'b0, busy}, 32'd0);
    check("drain_idle_in_ready", {31'b0, in_ready}, 32'd1);

    // Flush in FILL after 3 pixels with a 4th accepted on the flush cycle
    pix_clr = 1'b1;
    tick();
    pix_clr = 1'b0;
    in_valid = 1'b1;
    repeat (3) tick();
    check("ffill_occ3", {25'b0, occ}, 32'd3);
    flush = 1'b1;
    #1;
    check("ffill_flush_wen", {31'b0, mem_wen}, 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("ffill_occ4", {25'b0, occ}, 32'd4);
    wait_out_valid("ffill_drain_start");
    for (int j = 0; j < 4; j++) begin
      check("ffill_rdata", {16'b0, mem_rdata}, 32'(j));
      check("ffill_eol", {31'b0, out_eol}, 32'd0);
      tick();
    end
    check("ffill_idle_busy", {31'b0, busy}, 32'd0);
    check("ffill_occ0", {25'b0, occ}, 32'd0);

    // Error: mem_full with occ=2
    in_valid = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    check("err_pre", {31'b0, err}, 32'd0);
    force_full = 1'b1;
    tick();
    force_full = 1'b0;
    check("err_set", {31'b0, err}, 32'd1);
    tick();
    check("err_sticky", {31'b0, err}, 32'd1);

    // Reach STREAM, then asynchronous reset between clock edges
    in_valid = 1'b1;
    repeat (LWIDTH - 2) tick();
    check("mid_occ", {25'b0, occ}, 32'd8);
    #1;
    check("mid_out_valid", {31'b0, out_valid}, 32'd1);
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_occ", {25'b0, occ}, 32'd0);
    check("arst_err", {31'b0, err}, 32'd0);
    check("arst_mem_clr", {31'b0, mem_clr}, 32'd1);
    check("arst_busy", {31'b0, busy}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("arst_init_clr", {31'b0, mem_clr}, 32'd1);
    check("arst_init_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("arst_idle_clr", {31'b0, mem_clr}, 32'd0);
    check("arst_idle_ready", {31'b0, in_ready}, 32'd1);
    check("arst_idle_occ", {25'b0, occ}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
